// File: rtl/mrv1_itag_pkg.sv
// Shared types and sizing helpers for the per-thread itag queue.
package mrv1_itag_pkg;

  localparam int ITAG_WIDTH_DEF    = 3;
  localparam int RF_ADDR_WIDTH_DEF = 5;

  function automatic int iqueue_depth(input int itag_w);
    return 1 << itag_w;
  endfunction

  typedef logic [ITAG_WIDTH_DEF-1:0] itag_t;

  typedef struct packed {
    logic                         vld;
    logic                         rd_vld;
    logic [RF_ADDR_WIDTH_DEF-1:0] rd_addr;
  } entry_t;

endpackage

// File: rtl/mrv1_itag_queue_tw.sv
// One thread's circular itag queue: head/tail/count plus per-entry rd tracking.
module mrv1_itag_queue_tw
  import mrv1_itag_pkg::*;
#(
  parameter int ITAG_WIDTH_P    = ITAG_WIDTH_DEF,
  parameter int RF_ADDR_WIDTH_P = RF_ADDR_WIDTH_DEF
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic                                                      flush_i,
  input  logic                                                      alloc_i,
  input  logic                                                      alloc_rd_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0]                                alloc_rd_addr_i,
  input  logic [ITAG_WIDTH_P-1:0]                                   retire_cnt_i,
  output logic [ITAG_WIDTH_P-1:0]                                   head_o,
  output logic [ITAG_WIDTH_P-1:0]                                   tail_o,
  output logic [ITAG_WIDTH_P:0]                                     cnt_o,
  output logic [iqueue_depth(ITAG_WIDTH_P)-1:0]                     rd_vld_o,
  output logic [iqueue_depth(ITAG_WIDTH_P)-1:0][RF_ADDR_WIDTH_P-1:0] rd_addr_o
);

  localparam int DEPTH = iqueue_depth(ITAG_WIDTH_P);

  logic [ITAG_WIDTH_P-1:0]                 head_q, tail_q;
  logic [ITAG_WIDTH_P:0]                   cnt_q;
  logic [DEPTH-1:0]                        vld_q, rd_vld_q;
  logic [DEPTH-1:0][RF_ADDR_WIDTH_P-1:0]   rd_addr_q;

  logic [ITAG_WIDTH_P-1:0] k_eff, offs;
  logic [DEPTH-1:0]        clr, set;

  // Entry i is retired when its distance from head falls inside the retire window.
  always_comb begin
    k_eff = ({1'b0, retire_cnt_i} > cnt_q) ? cnt_q[ITAG_WIDTH_P-1:0] : retire_cnt_i;
    clr   = '0;
    set   = '0;
    offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs   = ITAG_WIDTH_P'(i) - head_q;
      clr[i] = offs < k_eff;
    end
    if (alloc_i) set[tail_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      rd_vld_q <= '0;
    end else begin
      head_q   <= head_q + k_eff;
      tail_q   <= tail_q + ITAG_WIDTH_P'(alloc_i);
      cnt_q    <= cnt_q + (ITAG_WIDTH_P+1)'(alloc_i) - {1'b0, k_eff};
      vld_q    <= (vld_q & ~clr) | set;
      rd_vld_q <= (rd_vld_q & ~clr) | (alloc_rd_vld_i ? set : '0);
    end
  end

  // Address storage carries no reset; consumers qualify it with rd_vld.
  always_ff @(posedge clk_i) begin
    if (alloc_i) rd_addr_q[tail_q] <= alloc_rd_addr_i;
  end

  a_retire_le_cnt: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    ({1'b0, retire_cnt_i} <= cnt_q));

  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign cnt_o     = cnt_q;
  assign rd_vld_o  = vld_q & rd_vld_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: rtl/mrv1_itag_queue.sv
// Per-thread in-order itag allocator / destination tracker feeding retire.
// Optional per-thread flush port enabled by defining MRV1_ITAG_QUEUE_FLUSH_EN.
module mrv1_itag_queue
  import mrv1_itag_pkg::*;
#(
  parameter int NUM_TW_P        = 8,
  parameter int ITAG_WIDTH_P    = ITAG_WIDTH_DEF,
  parameter int rf_addr_width_p = RF_ADDR_WIDTH_DEF,
  localparam int iqueue_size_lp = iqueue_depth(ITAG_WIDTH_P),
  localparam int twid_width_lp  = $clog2(NUM_TW_P)
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
`ifdef MRV1_ITAG_QUEUE_FLUSH_EN
  input  logic [NUM_TW_P-1:0]                                           flush_i,
`endif
  input  logic                                                          alloc_vld_i,
  input  logic [twid_width_lp-1:0]                                      alloc_twid_i,
  input  logic                                                          alloc_rd_vld_i,
  input  logic [rf_addr_width_p-1:0]                                    alloc_rd_addr_i,
  output logic                                                          alloc_rdy_o,
  output logic [ITAG_WIDTH_P-1:0]                                       alloc_itag_o,
  input  logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]                         retire_cnt_i,
  output logic [NUM_TW_P-1:0]                                           retire_rdy_o,
  output logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]                         retire_itag_o,
  output logic [NUM_TW_P-1:0][iqueue_size_lp-1:0]                       iq_rd_vld_o,
  output logic [NUM_TW_P-1:0][iqueue_size_lp-1:0][rf_addr_width_p-1:0]  iq_rd_addr_o,
  output logic [NUM_TW_P-1:0][ITAG_WIDTH_P:0]                           occupancy_o
);

  logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0] head, tail;
  logic [NUM_TW_P-1:0][ITAG_WIDTH_P:0]   cnt;
  logic [NUM_TW_P-1:0]                   flush, alloc_sel;
  logic                                  alloc_fire;

`ifdef MRV1_ITAG_QUEUE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = '0;
`endif

  // Readiness uses registered count only, so a full thread cannot refill on its retire cycle.
  assign alloc_rdy_o  = (cnt[alloc_twid_i] != (ITAG_WIDTH_P+1)'(iqueue_size_lp))
                        && !flush[alloc_twid_i];
  assign alloc_itag_o = tail[alloc_twid_i];
  assign alloc_fire   = alloc_vld_i && alloc_rdy_o;

  for (genvar g = 0; g < NUM_TW_P; g++) begin : g_tw
    assign alloc_sel[g] = alloc_fire && (alloc_twid_i == twid_width_lp'(g));

    mrv1_itag_queue_tw #(
      .ITAG_WIDTH_P    (ITAG_WIDTH_P),
      .RF_ADDR_WIDTH_P (rf_addr_width_p)
    ) u_tw (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush[g]),
      .alloc_i         (alloc_sel[g]),
      .alloc_rd_vld_i  (alloc_rd_vld_i),
      .alloc_rd_addr_i (alloc_rd_addr_i),
      .retire_cnt_i    (retire_cnt_i[g]),
      .head_o          (head[g]),
      .tail_o          (tail[g]),
      .cnt_o           (cnt[g]),
      .rd_vld_o        (iq_rd_vld_o[g]),
      .rd_addr_o       (iq_rd_addr_o[g])
    );

    assign retire_rdy_o[g] = |cnt[g];
  end

  assign retire_itag_o = head;
  assign occupancy_o   = cnt;

endmodule

// File: tb/tb_mrv1_itag_queue.sv
// Directed vector table, hand-written corner sequences and a queue-based random model.
module tb_mrv1_itag_queue;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           flush;
  logic                 alloc_vld;
  logic [2:0]           alloc_twid;
  logic                 alloc_rd_vld;
  logic [4:0]           alloc_rd_addr;
  logic                 alloc_rdy;
  logic [2:0]           alloc_itag;
  logic [7:0][2:0]      retire_cnt;
  logic [7:0]           retire_rdy;
  logic [7:0][2:0]      retire_itag;
  logic [7:0][7:0]      iq_rd_vld;
  logic [7:0][7:0][4:0] iq_rd_addr;
  logic [7:0][3:0]      occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mrv1_itag_queue dut (
    .clk_i           (clk),
    .rst_i           (rst),
`ifdef MRV1_ITAG_QUEUE_FLUSH_EN
    .flush_i         (flush),
`endif
    .alloc_vld_i     (alloc_vld),
    .alloc_twid_i    (alloc_twid),
    .alloc_rd_vld_i  (alloc_rd_vld),
    .alloc_rd_addr_i (alloc_rd_addr),
    .alloc_rdy_o     (alloc_rdy),
    .alloc_itag_o    (alloc_itag),
    .retire_cnt_i    (retire_cnt),
    .retire_rdy_o    (retire_rdy),
    .retire_itag_o   (retire_itag),
    .iq_rd_vld_o     (iq_rd_vld),
    .iq_rd_addr_o    (iq_rd_addr),
    .occupancy_o     (occupancy)
  );

  typedef struct {
    logic       vld;
    logic [2:0] twid;
    logic       rdv;
    logic [4:0] rda;
    logic       exp_rdy;
    logic [2:0] exp_itag;
  } vec_t;

  typedef struct {
    logic       rv;
    logic [4:0] ra;
  } ent_t;

  ent_t mq[8][$];
  int   m_head[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_vld = 0; alloc_twid = 0; alloc_rd_vld = 0; alloc_rd_addr = 0;
    retire_cnt = '0; flush = '0; rst = 0;
  endtask

  task automatic alloc(input int t, input logic rv, input logic [4:0] ra);
    alloc_vld = 1; alloc_twid = 3'(t); alloc_rd_vld = rv; alloc_rd_addr = ra;
    tick();
    alloc_vld = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_retire_rdy"}, 64'(retire_rdy), 0);
    chk({tag, "_retire_itag"}, 64'(retire_itag), 0);
    chk({tag, "_iq_rd_vld"}, 64'(iq_rd_vld), 0);
    chk({tag, "_occupancy"}, 64'(occupancy), 0);
    chk({tag, "_alloc_rdy"}, 64'(alloc_rdy), 1);
  endtask

  // Compare every output against the model's view of the pre-edge state.
  task automatic chk_model();
    int sz, idx;
    logic [7:0] ev;
    for (int t = 0; t < 8; t++) begin
      sz = mq[t].size();
      ev = '0;
      chk($sformatf("rnd_occ[%0d]", t), 64'(occupancy[t]), 64'(sz));
      chk($sformatf("rnd_rdy[%0d]", t), 64'(retire_rdy[t]), 64'(sz != 0));
      chk($sformatf("rnd_head[%0d]", t), 64'(retire_itag[t]), 64'(m_head[t]));
      for (int j = 0; j < sz; j++) begin
        idx = (m_head[t] + j) % 8;
        ev[idx] = mq[t][j].rv;
        if (mq[t][j].rv)
          chk($sformatf("rnd_rd_addr[%0d][%0d]", t, idx), 64'(iq_rd_addr[t][idx]), 64'(mq[t][j].ra));
      end
      chk($sformatf("rnd_rd_vld[%0d]", t), 64'(iq_rd_vld[t]), 64'(ev));
    end
    chk("rnd_alloc_rdy", 64'(alloc_rdy),
        64'(mq[alloc_twid].size() != 8 && !flush[alloc_twid]));
    chk("rnd_alloc_itag", 64'(alloc_itag), 64'((m_head[alloc_twid] + mq[alloc_twid].size()) % 8));
  endtask

  task automatic model_step();
    bit fire;
    ent_t e;
    if (rst) begin
      for (int t = 0; t < 8; t++) begin mq[t].delete(); m_head[t] = 0; end
      return;
    end
    fire = alloc_vld && mq[alloc_twid].size() != 8 && !flush[alloc_twid];
    for (int t = 0; t < 8; t++) begin
      if (flush[t]) begin
        mq[t].delete(); m_head[t] = 0;
      end else begin
        for (int k = 0; k < int'(retire_cnt[t]); k++) void'(mq[t].pop_front());
        m_head[t] = (m_head[t] + int'(retire_cnt[t])) % 8;
      end
    end
    if (fire) begin
      e.rv = alloc_rd_vld; e.ra = alloc_rd_addr;
      mq[alloc_twid].push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[10];
    int lim;

    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 3'd2, 1'b1, 5'(i + 1), 1'b1, 3'(i)};
    vt[8] = '{1'b1, 3'd2, 1'b1, 5'd9, 1'b0, 3'd0};
    vt[9] = '{1'b0, 3'd3, 1'b0, 5'd0, 1'b1, 3'd0};

    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_reset_state("reset");

    // Fill thread 2, then probe full/other-thread readiness.
    for (int i = 0; i < 10; i++) begin
      alloc_vld = vt[i].vld; alloc_twid = vt[i].twid;
      alloc_rd_vld = vt[i].rdv; alloc_rd_addr = vt[i].rda;
      #1;
      chk($sformatf("vec%0d_alloc_rdy", i), 64'(alloc_rdy), 64'(vt[i].exp_rdy));
      chk($sformatf("vec%0d_alloc_itag", i), 64'(alloc_itag), 64'(vt[i].exp_itag));
      tick();
    end
    idle();
    chk("full_occ2", 64'(occupancy[2]), 8);
    chk("full_vld2", 64'(iq_rd_vld[2]), 64'h0FF);
    chk("full_retire_rdy", 64'(retire_rdy), 64'h04);
    chk("full_rd_addr2_5", 64'(iq_rd_addr[2][5]), 6);

    // Retire 3 from full while dispatch keeps asking; no same-cycle refill.
    retire_cnt[2] = 3; alloc_vld = 1; alloc_twid = 2; alloc_rd_vld = 1; alloc_rd_addr = 5'd30;
    #1;
    chk("full_retire_cycle_rdy", 64'(alloc_rdy), 0);
    tick();
    idle();
    alloc_twid = 2;
    #1;
    chk("ret3_head2", 64'(retire_itag[2]), 3);
    chk("ret3_occ2", 64'(occupancy[2]), 5);
    chk("ret3_vld2", 64'(iq_rd_vld[2]), 64'h0F8);
    chk("ret3_alloc_rdy", 64'(alloc_rdy), 1);

    // Tail wraps: itags 0,1,2.
    for (int i = 0; i < 3; i++) begin
      alloc_vld = 1; alloc_twid = 2; alloc_rd_vld = 1; alloc_rd_addr = 5'(20 + i);
      #1;
      chk($sformatf("wrap_itag%0d", i), 64'(alloc_itag), 64'(i));
      tick();
    end
    idle();
    chk("wrap_occ2", 64'(occupancy[2]), 8);
    retire_cnt[2] = 7;
    tick();
    chk("ret7_head2", 64'(retire_itag[2]), 2);
    chk("ret7_occ2", 64'(occupancy[2]), 1);
    chk("ret7_vld2", 64'(iq_rd_vld[2]), 64'h04);
    chk("ret7_rd_addr", 64'(iq_rd_addr[2][2]), 22);
    retire_cnt[2] = 1;
    tick();
    idle();
    chk("ret1_head2", 64'(retire_itag[2]), 3);
    chk("ret1_occ2", 64'(occupancy[2]), 0);
    chk("ret1_retire_rdy2", 64'(retire_rdy[2]), 0);
    chk("ret1_vld2", 64'(iq_rd_vld[2]), 0);

    // Thread 5: simultaneous alloc and retire with 4 live entries.
    for (int i = 0; i < 4; i++) alloc(5, 1'b1, 5'(10 + i));
    alloc_vld = 1; alloc_twid = 5; alloc_rd_vld = 1; alloc_rd_addr = 5'd14; retire_cnt[5] = 1;
    #1;
    chk("same_cyc_itag", 64'(alloc_itag), 4);
    tick();
    idle();
    alloc_twid = 5;
    #1;
    chk("same_cyc_occ5", 64'(occupancy[5]), 4);
    chk("same_cyc_head5", 64'(retire_itag[5]), 1);
    chk("same_cyc_tail5", 64'(alloc_itag), 5);
    chk("same_cyc_vld5", 64'(iq_rd_vld[5]), 64'h1E);

    // Entry without a destination register.
    alloc(6, 1'b0, 5'd7);
    idle();
    chk("nord_occ6", 64'(occupancy[6]), 1);
    chk("nord_vld6", 64'(iq_rd_vld[6]), 0);
    chk("nord_retire_rdy", 64'(retire_rdy), 64'h60);

`ifdef MRV1_ITAG_QUEUE_FLUSH_EN
    for (int i = 0; i < 6; i++) alloc(1, 1'b1, 5'(i));
    chk("pre_flush_occ1", 64'(occupancy[1]), 6);
    flush[1] = 1; alloc_vld = 1; alloc_twid = 1; alloc_rd_vld = 1; alloc_rd_addr = 5'd3;
    #1;
    chk("flush_alloc_rdy", 64'(alloc_rdy), 0);
    tick();
    idle();
    alloc_twid = 1;
    #1;
    chk("flush_occ1", 64'(occupancy[1]), 0);
    chk("flush_itag1", 64'(alloc_itag), 0);
    chk("flush_vld1", 64'(iq_rd_vld[1]), 0);
    chk("flush_keeps_t5", 64'(occupancy[5]), 4);
`endif

    // Mid-stream reset with live entries on threads 5 and 6.
    rst = 1; alloc_vld = 1; alloc_twid = 5; alloc_rd_vld = 1; retire_cnt[6] = 1;
    tick();
    idle();
    chk_reset_state("midrst");

    // Randomized phase against the queue model.
    for (int t = 0; t < 8; t++) begin mq[t].delete(); m_head[t] = 0; end
    for (int c = 0; c < 3000; c++) begin
      rst           = (c == 1500);
      alloc_vld     = ($urandom % 4) != 0;
      alloc_twid    = 3'($urandom % 8);
      alloc_rd_vld  = 1'($urandom % 2);
      alloc_rd_addr = 5'($urandom);
      flush         = '0;
`ifdef MRV1_ITAG_QUEUE_FLUSH_EN
      if ($urandom % 64 == 0) flush[$urandom % 8] = 1'b1;
`endif
      for (int t = 0; t < 8; t++) begin
        lim = mq[t].size() < 7 ? mq[t].size() : 7;
        retire_cnt[t] = ($urandom % 6 == 0 && !rst) ? 3'($urandom_range(0, lim)) : 3'd0;
      end
      #1;
      chk_model();
      model_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
